score_keeper: RTL

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper_pkg.sv | 36 +++
 rtl/score_keeper_if.sv | 32 +++
 rtl/score_keeper_event_edge.sv | 42 ++++
 rtl/score_keeper.sv | 103 ++++++++++
 4 files changed

// File: rtl/score_keeper_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : score_pkg
//  Purpose  : Shared widths, saturation ceiling default, FSM state encoding
//             and a saturating adder for the score keeper and the blocks that
//             consume its 14-bit values (BCD converters, display).
//  Contents : SCORE_W, SUM_W, SCORE_MAX_DEF, state_t, sat_add()
//  Revision : 1.0 - initial release
// ============================================================================
package score_pkg;

    localparam int SCORE_W       = 14;
    localparam int SUM_W         = 16;
    localparam int SCORE_MAX_DEF = 9999;

    typedef enum logic [1:0] {
        ST_PLAY   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_HOLD   = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

    // The 16-bit intermediate leaves headroom above a 14-bit operand, so the
    // ceiling comparison cannot be fooled by a carry out of the 14-bit range.
    function automatic logic [SCORE_W-1:0] sat_add(
        input logic [SCORE_W-1:0] a,
        input logic [1:0]         inc,
        input logic [SCORE_W-1:0] max
    );
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(inc);
        return (s > SUM_W'(max)) ? max : s[SCORE_W-1:0];
    endfunction

endpackage : score_pkg
`default_nettype wire

// File: rtl/score_keeper_if.sv
`default_nettype none
// ============================================================================
//  Module   : score_keeper_if
//  Purpose  : Bundles the game-event inputs and score outputs of score_keeper.
//  Signals  : pause, event_in[3:0]            (master -> slave)
//             score, h_score, rounds [13:0],
//             new_high, state[1:0]            (slave -> master)
//  Modports : master (game / test side), slave (score_keeper)
//  Revision : 1.0 - initial release
// ============================================================================
interface score_keeper_if;
    import score_pkg::*;

    logic               pause;
    logic [3:0]         event_in;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] h_score;
    logic [SCORE_W-1:0] rounds;
    logic               new_high;
    logic [1:0]         state;

    modport master (
        output pause, event_in,
        input  score, h_score, rounds, new_high, state
    );

    modport slave (
        input  pause, event_in,
        output score, h_score, rounds, new_high, state
    );
endinterface : score_keeper_if
`default_nettype wire

// File: rtl/score_keeper_event_edge.sv
`default_nettype none
// ============================================================================
//  Module   : event_edge
//  Purpose  : Rising-edge detection on the four event levels plus a popcount
//             of the three dragon-hit edges. Runs regardless of pause so the
//             history is always current; the consumer decides what to drop.
//  Ports    : clk_22, rst (async, active-low), event_in[3:0]
//             hit[3:1], rnd_end, points[1:0]
//  Revision : 1.0 - initial release
// ============================================================================
module event_edge (
    input  wire logic       clk_22,
    input  wire logic       rst,
    input  wire logic [3:0] event_in,
    output logic [3:1]      hit,
    output logic            rnd_end,
    output logic [1:0]      points
);

    logic [3:0] r_prev;
    // Cleared by reset; set on the first clock after release. Until then the
    // history is not real, so levels already high at release give no edge.
    logic       r_armed;

    always_ff @(posedge clk_22 or negedge rst) begin
        if (!rst) begin
            r_prev  <= 4'b0000;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= event_in;
            r_armed <= 1'b1;
        end
    end

    logic [3:0] w_edge;
    assign w_edge  = r_armed ? (event_in & ~r_prev) : 4'b0000;
    assign hit     = w_edge[3:1];
    assign rnd_end = w_edge[0];
    assign points  = {1'b0, w_edge[3]} + {1'b0, w_edge[2]} + {1'b0, w_edge[1]};

endmodule : event_edge
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : score_keeper
//  Purpose  : Accumulates dragon-hit points per round, commits the round to a
//             high score and round counter, holds the final score for
//             HOLD_CYCLES ticks, then clears. All values saturate.
//  Ports    : clk_22, rst (async, active-low)
//             bus (score_keeper_if.slave): pause, event_in -> score, h_score,
//             rounds, new_high, state
//  Params   : SCORE_MAX   saturation ceiling (default 9999)
//             HOLD_CYCLES ticks the final score is held (default 8, >= 1)
//  Revision : 1.0 - initial release
// ============================================================================
module score_keeper
    import score_pkg::*;
#(
    parameter int SCORE_MAX   = SCORE_MAX_DEF,
    parameter int HOLD_CYCLES = 8
) (
    input  wire logic     clk_22,
    input  wire logic     rst,
    score_keeper_if.slave bus
);

    localparam int                 CNT_W       = $clog2(HOLD_CYCLES + 1);
    localparam logic [SCORE_W-1:0] c_MAX       = SCORE_W'(SCORE_MAX);
    localparam logic [CNT_W-1:0]   c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [3:1] w_hit;
    logic       w_rnd_end;
    logic [1:0] w_points;

    event_edge u_edge (
        .clk_22   (clk_22),
        .rst      (rst),
        .event_in (bus.event_in),
        .hit      (w_hit),
        .rnd_end  (w_rnd_end),
        .points   (w_points)
    );

    state_t             r_state;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_h_score;
    logic [SCORE_W-1:0] r_rounds;
    logic               r_new_high;

    // Pause freezes everything, so edges seen while paused are simply never
    // consumed; the detector keeps tracking levels, so they are not deferred.
    always_ff @(posedge clk_22 or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_PLAY;
            r_hold_cnt <= '0;
            r_score    <= '0;
            r_h_score  <= '0;
            r_rounds   <= '0;
            r_new_high <= 1'b0;
        end else if (!bus.pause) begin
            r_new_high <= 1'b0;
            case (r_state)
                ST_PLAY: begin
                    // Points land in the same cycle as a round end, so the
                    // commit sees the updated score.
                    if (w_hit != 3'b000) begin
                        r_score <= sat_add(r_score, w_points, c_MAX);
                    end
                    if (w_rnd_end) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    if (r_score > r_h_score) begin
                        r_h_score  <= r_score;
                        r_new_high <= 1'b1;
                    end
                    r_rounds   <= sat_add(r_rounds, 2'd1, c_MAX);
                    r_hold_cnt <= '0;
                    r_state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        r_state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_score <= '0;
                    r_state <= ST_PLAY;
                end
                default: r_state <= ST_PLAY;
            endcase
        end
    end

    assign bus.score    = r_score;
    assign bus.h_score  = r_h_score;
    assign bus.rounds   = r_rounds;
    assign bus.new_high = r_new_high;
    assign bus.state    = r_state;

endmodule : score_keeper
`default_nettype wire
